ddr3_avmm_arbiter: RTL

- Two-master Avalon-MM arbiter sharing the single DDR3 EMIF user port (amm_*) between two requesters, e.g. the SFP RX frame writer and the TX frame reader.
- Round-robin grant with a burst lock for writes.
- Read responses are routed back to their owner through an in-order tag FIFO.
- All traffic is gated on ddr3_status_local_cal_success; the block sits between the user datapath and the EMIF in the emif_usr_clk domain.

---
 rtl/ddr3_avmm_arbiter.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_avmm_arbiter.sv
// Two-master Avalon-MM arbiter onto one DDR3 EMIF user port, with an in-order read-tag FIFO for response routing.
// Latency: 1 cycle arbitration (IDLE->GRANT), command forwarded combinationally; read data routed combinationally.
// Backpressure: amm_waitrequest passed to the granted master only; reads stall when the tag FIFO is full; read return has none.

module ddr3_avmm_arbiter_tag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Pointers carry one wrap bit so full and empty can be told apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: contents are only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr[PTR_W-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
endmodule

module ddr3_avmm_arbiter #(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 256,
    parameter int BURST_W   = 7,
    parameter int MAX_OUTST = 16
) (
    input  logic                   emif_usr_clk_clk,
    input  logic                   emif_usr_reset_reset,
    input  logic                   ddr3_status_local_cal_success,
    input  logic [2*ADDR_W-1:0]    s_address,
    input  logic [1:0]             s_read,
    input  logic [1:0]             s_write,
    input  logic [2*BURST_W-1:0]   s_burstcount,
    input  logic [2*DATA_W-1:0]    s_writedata,
    output logic [1:0]             s_waitrequest,
    output logic [DATA_W-1:0]      s_readdata,
    output logic [1:0]             s_readdatavalid,
    output logic [ADDR_W-1:0]      amm_address,
    output logic                   amm_read,
    output logic                   amm_write,
    output logic [BURST_W-1:0]     amm_burstcount,
    output logic [DATA_W-1:0]      amm_writedata,
    output logic [DATA_W/8-1:0]    amm_byteenable,
    input  logic                   amm_waitrequest,
    input  logic [DATA_W-1:0]      amm_readdata,
    input  logic                   amm_readdatavalid,
    output logic                   rsp_err
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                gnt;
    logic                last;
    logic [BURST_W-1:0]  remaining;

    logic [1:0]          req;
    logic [ADDR_W-1:0]   sel_address;
    logic [BURST_W-1:0]  sel_burstcount;
    logic [DATA_W-1:0]   sel_writedata;
    logic                sel_read;
    logic                sel_write;
    logic                accept;

    logic                tag_push;
    logic                tag_pop;
    logic                tag_full;
    logic                tag_empty;
    logic [BURST_W:0]    tag_head;
    logic                head_id;
    logic [BURST_W-1:0]  head_bc;
    logic [BURST_W-1:0]  head_len;
    logic [BURST_W-1:0]  beat_cnt;
    logic                head_last_beat;
    logic                rsp_beat;

    assign req = s_read | s_write;

    // Granted master's command fields; also valid as data path during a locked burst.
    assign sel_address    = gnt ? s_address[2*ADDR_W-1:ADDR_W]     : s_address[ADDR_W-1:0];
    assign sel_burstcount = gnt ? s_burstcount[2*BURST_W-1:BURST_W] : s_burstcount[BURST_W-1:0];
    assign sel_writedata  = gnt ? s_writedata[2*DATA_W-1:DATA_W]   : s_writedata[DATA_W-1:0];
    // A master driving read and write together is treated as reading.
    assign sel_read       = s_read[gnt];
    assign sel_write      = s_write[gnt] & ~s_read[gnt];

    assign amm_address    = sel_address;
    assign amm_burstcount = sel_burstcount;
    assign amm_writedata  = sel_writedata;
    assign amm_byteenable = '1;

    assign accept   = (amm_read | amm_write) & ~amm_waitrequest;
    assign tag_push = (state == GRANT) & amm_read & ~amm_waitrequest;

    // State register.
    always_ff @(posedge emif_usr_clk_clk) begin
        if (emif_usr_reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, issue in GRANT, stream locked write beats in WR_BURST.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ddr3_status_local_cal_success && (|req)) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (amm_read || (sel_burstcount <= BURST_W'(1))) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WR_BURST;
                    end
                end else if (!req[gnt]) begin
                    // Granted master withdrew its request; re-arbitrate rather than wait forever.
                    state_nxt = IDLE;
                end
            end
            WR_BURST: begin
                if (accept && (remaining == BURST_W'(1))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: only the granted master sees the EMIF stall; everyone else is held off.
    always_comb begin
        amm_read      = 1'b0;
        amm_write     = 1'b0;
        s_waitrequest = 2'b11;
        case (state)
            GRANT: begin
                if (ddr3_status_local_cal_success) begin
                    if (sel_read) begin
                        if (!tag_full) begin
                            amm_read           = 1'b1;
                            s_waitrequest[gnt] = amm_waitrequest;
                        end
                    end else if (sel_write) begin
                        amm_write          = 1'b1;
                        s_waitrequest[gnt] = amm_waitrequest;
                    end
                end
            end
            WR_BURST: begin
                amm_write          = s_write[gnt];
                s_waitrequest[gnt] = amm_waitrequest;
            end
            default: ;
        endcase
    end

    // Grant, round-robin history and write-burst beat tracking.
    always_ff @(posedge emif_usr_clk_clk) begin
        if (emif_usr_reset_reset) begin
            gnt       <= 1'b0;
            last      <= 1'b1;
            remaining <= '0;
        end else begin
            if ((state == IDLE) && (state_nxt == GRANT)) begin
                gnt <= (&req) ? ~last : req[1];
            end
            if ((state == GRANT) && accept) begin
                last <= gnt;
                if (amm_write && (sel_burstcount > BURST_W'(1))) begin
                    remaining <= sel_burstcount - BURST_W'(1);
                end
            end else if ((state == WR_BURST) && accept) begin
                remaining <= remaining - BURST_W'(1);
            end
        end
    end

    ddr3_avmm_arbiter_tag_fifo #(
        .WIDTH (BURST_W + 1),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk      (emif_usr_clk_clk),
        .rst      (emif_usr_reset_reset),
        .push     (tag_push),
        .push_dat ({gnt, sel_burstcount}),
        .pop      (tag_pop),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    assign head_id        = tag_head[BURST_W];
    assign head_bc        = tag_head[BURST_W-1:0];
    assign head_len       = (head_bc == '0) ? BURST_W'(1) : head_bc;
    assign rsp_beat       = amm_readdatavalid & ~tag_empty;
    assign head_last_beat = (beat_cnt == (head_len - BURST_W'(1)));
    assign tag_pop        = rsp_beat & head_last_beat;
    assign s_readdata     = amm_readdata;

    // Route each returning beat to the owner of the oldest outstanding read.
    always_comb begin
        s_readdatavalid = 2'b00;
        if (rsp_beat) begin
            s_readdatavalid[head_id] = 1'b1;
        end
    end

    // Beat counter within the head read; sticky error on a beat with no owner.
    always_ff @(posedge emif_usr_clk_clk) begin
        if (emif_usr_reset_reset) begin
            beat_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (rsp_beat) begin
                beat_cnt <= head_last_beat ? '0 : (beat_cnt + BURST_W'(1));
            end
            if (amm_readdatavalid && tag_empty) begin
                rsp_err <= 1'b1;
            end
        end
    end
endmodule
